rv32_dmem_watch: RTL
====================

# rv32_dmem_watch

Parametrised single-clock data memory for the rv32is core with a built-in store-watch FIFO. It replaces the separate read/write memory clocks of the current harness with one clock, implements all RV32I load/store widths selected by `dmemop`, and captures every store aimed at a configurable watch address into a FIFO so benches and board debug logic can read register values without probing the core. It sits between the core's `dmem*` ports and the bench or board top level.

## Interface
- `ADDR_WIDTH`, 12, word-address bits; memory holds 2^ADDR_WIDTH 32-bit words (byte address bits [ADDR_WIDTH+1:2] used, upper bits ignored)
- `WATCH_ADDR`, 32'h0000_0000, byte address whose word is watched (bits [1:0] ignored)
- `WATCH_DEPTH`, 8, watch FIFO entries; power of two, ≥2
- `clock`  in  1  sole clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset (sampled on rising `clock`; 0 = reset)
- `dmemaddr`  in  32  byte address from core
- `dmemdatain`  in  32  store data from core (value in low bits)
- `dmemwe`  in  1  store request this cycle
- `dmemop`  in  3  access size: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; others reserved
- `dmemdataout`  out  32  registered load data, sign/zero-extended
- `watch_data`  out  32  head-of-FIFO stored value
- `watch_valid`  out  1  FIFO non-empty
- `watch_ready`  in  1  consumer pops head when high with `watch_valid`
- `watch_count`  out  $clog2(WATCH_DEPTH)+1  current occupancy
- `watch_overflow`  out  1  sticky: a watched store was dropped
- `misalign`  out  1  sticky: misaligned or reserved-op access seen
- `misalign_addr`  out  32  address of first such access

## Operation
- Storage: 32-bit words, four byte lanes. Contents not cleared by reset.
- Store (`dmemwe`=1): byte op writes lane `dmemaddr[1:0]` with `dmemdatain[7:0]`; half op writes lanes {1,0} or {3,2} per `dmemaddr[1]` with `dmemdatain[15:0]`; word writes all lanes. Unsigned codes behave like signed for stores.
- Load (every cycle, `dmemwe` ignored): selected byte/half extracted and right-aligned; codes 000/001 sign-extend, 100/101 zero-extend, 010 full word.
- Misalignment: half with `dmemaddr[0]`=1, word with `dmemaddr[1:0]`≠0, or reserved `dmemop` (011,110,111). Store is suppressed; load returns 0. `misalign` sets, `misalign_addr` captures address only on the first event after reset.
- Watch: an aligned, non-suppressed store with `dmemaddr[ADDR_WIDTH+1:2]` = `WATCH_ADDR[ADDR_WIDTH+1:2]` pushes `dmemdatain` masked to store size (upper bits zero) into the FIFO. The store also updates memory normally.
- FIFO: circular buffer, read/write pointers wrap at WATCH_DEPTH. `watch_data` shows head combinationally from storage; undefined-free: 0 when empty.
- Push when full: if a pop occurs same cycle, push accepted (count unchanged); otherwise entry dropped, `watch_overflow` set.
- Pop when empty: ignored.

## Timing
- Load latency 1: address/op at edge N → `dmemdataout` valid after edge N, held until next edge.
- Store latency 1: committed at edge N; a load of same word issued at edge N returns old data (read-before-write); load at N+1 returns new data.
- Watch push at edge N → `watch_valid`=1, `watch_count` incremented after edge N.
- Pop at edge N (valid & ready) → next entry on `watch_data` after edge N; back-to-back pops allowed every cycle.
- Reset (`reset`=0 at an edge, also mid-operation): `dmemdataout`=0, FIFO emptied (`watch_valid`=0, `watch_count`=0, `watch_data`=0), `watch_overflow`=0, `misalign`=0, `misalign_addr`=0; stores presented during reset are not committed or pushed.

## Test plan
- Word store 32'h0000_0064 to 0x40, then lw 0x40 → `dmemdataout`=32'h0000_0064 one cycle later; read in store cycle returns prior value.
- Word 32'h8081_F0FF at 0x10; lb 0x10 → 32'hFFFF_FFFF, lbu 0x11 → 32'h0000_00F0, lh 0x12 → 32'hFFFF_8081, lhu 0x12 → 32'h0000_8081; sb 8'h12 to 0x13 → lw = 32'h1281_F0FF.
- WATCH_ADDR=0, stores x6=100, x7=20 (sw to 0x0) with `watch_ready`=0 → `watch_count`=2, `watch_data`=100; pop → 20; pop → `watch_valid`=0.
- WATCH_DEPTH=8: 9 watched stores, ready low → count 8, `watch_overflow`=1, entries 1..8 retained; full with push+pop same cycle → count stays 8, overflow unchanged.
- lw at 0x6 then sh at 0x5 → `misalign`=1, `misalign_addr`=0x6, load 0, memory unchanged, no FIFO push.
- Reset asserted with 3 entries queued and `misalign` set → all outputs 0 after edge; memory word at 0x40 still reads 32'h0000_0064.

Source files
------------

// File: rtl/rv32_dmem_watch_if.sv
// rv32_dmem_watch_if
// Bundles the core-side data memory bus and the store-watch FIFO read port
// of rv32_dmem_watch.
//   master : the core / bench side. Drives the address, store data, write
//            enable, access size and the FIFO pop request.
//   slave  : the memory. Returns load data, FIFO head/valid/occupancy and the
//            sticky error flags.
// WATCH_DEPTH only sets the width of watch_count. It must match the
// WATCH_DEPTH of the memory instance that uses this interface.
interface rv32_dmem_watch_if #(
  parameter int WATCH_DEPTH = 8
);
  localparam int CW = $clog2(WATCH_DEPTH) + 1;

  logic [31:0]   dmemaddr;
  logic [31:0]   dmemdatain;
  logic          dmemwe;
  logic [2:0]    dmemop;
  logic [31:0]   dmemdataout;
  logic [31:0]   watch_data;
  logic          watch_valid;
  logic          watch_ready;
  logic [CW-1:0] watch_count;
  logic          watch_overflow;
  logic          misalign;
  logic [31:0]   misalign_addr;

  modport master (
    output dmemaddr, dmemdatain, dmemwe, dmemop, watch_ready,
    input  dmemdataout, watch_data, watch_valid, watch_count,
           watch_overflow, misalign, misalign_addr
  );

  modport slave (
    input  dmemaddr, dmemdatain, dmemwe, dmemop, watch_ready,
    output dmemdataout, watch_data, watch_valid, watch_count,
           watch_overflow, misalign, misalign_addr
  );
endinterface

// File: rtl/rv32_dmem_watch.sv
// rv32_dmem_watch
// Single-clock data memory for the rv32is core with a store-watch FIFO.
// It supports all RV32I load/store widths. Every aligned store that hits
// the word at WATCH_ADDR is copied into a small FIFO, so a bench or board
// logic can follow register values without probing the core.
//
// Ports
//   clock  : sole clock, rising edge
//   reset  : synchronous, active low (0 = reset)
//   bus    : rv32_dmem_watch_if.slave
//     dmemaddr/dmemdatain/dmemwe/dmemop : access request from the core
//     dmemdataout    : registered load data, sign/zero extended
//     watch_data     : FIFO head (0 when empty)
//     watch_valid    : FIFO non-empty
//     watch_ready    : pop request from the consumer
//     watch_count    : FIFO occupancy
//     watch_overflow : sticky, a watched store was dropped
//     misalign       : sticky, misaligned or reserved-op access seen
//     misalign_addr  : address of the first such access
module rv32_dmem_watch #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] WATCH_ADDR  = 32'h0000_0000,
  parameter int          WATCH_DEPTH = 8
) (
  input logic              clock,
  input logic              reset,
  rv32_dmem_watch_if.slave bus
);

  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam int PW    = $clog2(WATCH_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [CW-1:0]         FULL_CNT  = CW'(WATCH_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WATCH_IDX = WATCH_ADDR[ADDR_WIDTH+1:2];

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_BAD
  } size_e;

  logic [31:0] r_mem [0:WORDS-1];
  logic [31:0] r_fifo [0:WATCH_DEPTH-1];

  logic [31:0] r_dout;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic        r_overflow;
  logic        r_misalign;
  logic [31:0] r_misalignAddr;

  size_e       w_size;
  logic        w_unsigned;
  logic        w_misalign;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]  w_lane;
  logic        w_store;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_pushData;
  logic [31:0] w_rdWord;
  logic [7:0]  w_rdByte;
  logic [15:0] w_rdHalf;
  logic [31:0] w_loadData;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_pushOk;

  assign w_idx  = bus.dmemaddr[ADDR_WIDTH+1:2];
  assign w_lane = bus.dmemaddr[1:0];

  // Access size decode. The unsigned codes differ only in how loads are
  // extended. Every other code is reserved and treated as a fault.
  always_comb begin
    w_size     = SZ_BAD;
    w_unsigned = 1'b0;
    case (bus.dmemop)
      3'b000: w_size = SZ_BYTE;
      3'b001: w_size = SZ_HALF;
      3'b010: w_size = SZ_WORD;
      3'b100: begin w_size = SZ_BYTE; w_unsigned = 1'b1; end
      3'b101: begin w_size = SZ_HALF; w_unsigned = 1'b1; end
      default: w_size = SZ_BAD;
    endcase
  end

  // A fault suppresses the store and forces the load result to zero.
  always_comb begin
    w_misalign = 1'b0;
    case (w_size)
      SZ_HALF: w_misalign = bus.dmemaddr[0];
      SZ_WORD: w_misalign = |bus.dmemaddr[1:0];
      SZ_BAD:  w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  // Stores presented while reset is low are dropped as well.
  assign w_store = reset && bus.dmemwe && !w_misalign;

  // The store data is replicated across the lanes so each byte enable can
  // pick its own byte. The watch copy is the store value masked to its size.
  always_comb begin
    w_be       = 4'b0000;
    w_wdata    = bus.dmemdatain;
    w_pushData = bus.dmemdatain;
    case (w_size)
      SZ_BYTE: begin
        w_be       = 4'b0001 << w_lane;
        w_wdata    = {4{bus.dmemdatain[7:0]}};
        w_pushData = {24'h0, bus.dmemdatain[7:0]};
      end
      SZ_HALF: begin
        w_be       = bus.dmemaddr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{bus.dmemdatain[15:0]}};
        w_pushData = {16'h0, bus.dmemdatain[15:0]};
      end
      SZ_WORD: begin
        w_be       = 4'b1111;
      end
      default: begin
        w_be       = 4'b0000;
      end
    endcase
  end

  // Memory array. It is not reset, so contents survive a core reset.
  always_ff @(posedge clock) begin
    if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // The read is taken from the array before this edge's write lands, which
  // gives read-before-write behaviour for a same-word load and store.
  assign w_rdWord = r_mem[w_idx];
  assign w_rdByte = w_rdWord[{w_lane, 3'b000} +: 8];
  assign w_rdHalf = bus.dmemaddr[1] ? w_rdWord[31:16] : w_rdWord[15:0];

  always_comb begin
    w_loadData = 32'h0;
    if (!w_misalign) begin
      case (w_size)
        SZ_BYTE: w_loadData = w_unsigned ? {24'h0, w_rdByte}
                                         : {{24{w_rdByte[7]}}, w_rdByte};
        SZ_HALF: w_loadData = w_unsigned ? {16'h0, w_rdHalf}
                                         : {{16{w_rdHalf[15]}}, w_rdHalf};
        SZ_WORD: w_loadData = w_rdWord;
        default: w_loadData = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) r_dout <= 32'h0;
    else        r_dout <= w_loadData;
  end

  // Watch FIFO. When the FIFO is full, a push is still accepted if a pop
  // frees a slot in the same cycle. Otherwise the push is dropped and the
  // overflow flag is set.
  assign w_push   = w_store && (w_idx == WATCH_IDX);
  assign w_pop    = (r_count != '0) && bus.watch_ready;
  assign w_full   = (r_count == FULL_CNT);
  assign w_pushOk = w_push && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (w_pushOk) r_fifo[r_wrPtr] <= w_pushData;
  end

  // The pointers wrap on their own because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)    r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_pushOk) r_overflow <= 1'b1;
    end
  end

  // Only the first fault after reset records its address.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_misalign     <= 1'b0;
      r_misalignAddr <= 32'h0;
    end else if (w_misalign && !r_misalign) begin
      r_misalign     <= 1'b1;
      r_misalignAddr <= bus.dmemaddr;
    end
  end

  assign bus.dmemdataout    = r_dout;
  assign bus.watch_data     = (r_count != '0) ? r_fifo[r_rdPtr] : 32'h0;
  assign bus.watch_valid    = (r_count != '0);
  assign bus.watch_count    = r_count;
  assign bus.watch_overflow = r_overflow;
  assign bus.misalign       = r_misalign;
  assign bus.misalign_addr  = r_misalignAddr;

endmodule
